// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Purpose  : Write-back stage and architectural register file for the SEQ
//            Y86-64 core. Decodes the E/M destinations from the retiring
//            instruction, commits valE/valM on the clock edge, exposes two
//            combinational read ports for decode, tracks the halted state
//            and counts retired instructions.
// Ports    : clk, rst_n (synchronous, active-low)
//            wb_en, icode, rA, rB, Cnd, valE, valM   - retiring instruction
//            srcA, srcB -> valA, valB                - decode read ports
//            dstE, dstM                              - decoded destinations
//            halted, retired                         - status
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int NREGS = 15,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_en,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             Cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic             halted,
    output logic [63:0]      retired
);

    localparam logic [3:0] c_I_HALT   = 4'd0;
    localparam logic [3:0] c_I_RRMOVQ = 4'd2;
    localparam logic [3:0] c_I_IRMOVQ = 4'd3;
    localparam logic [3:0] c_I_MRMOVQ = 4'd5;
    localparam logic [3:0] c_I_OPQ    = 4'd6;
    localparam logic [3:0] c_I_CALL   = 4'd8;
    localparam logic [3:0] c_I_RET    = 4'd9;
    localparam logic [3:0] c_I_PUSHQ  = 4'd10;
    localparam logic [3:0] c_I_POPQ   = 4'd11;
    localparam logic [3:0] c_RSP      = 4'd4;
    localparam logic [3:0] c_RNONE    = 4'd15;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_halted;
    logic [63:0]      r_retired;

    logic [3:0]       w_dstE;
    logic [3:0]       w_dstM;
    logic             w_commit;
    logic [WIDTH-1:0] w_valA;
    logic [WIDTH-1:0] w_valB;

    // Destination decode, independent of wb_en and halted.
    always_comb begin
        w_dstE = c_RNONE;
        w_dstM = c_RNONE;
        case (icode)
            c_I_RRMOVQ: w_dstE = Cnd ? rB : c_RNONE;
            c_I_IRMOVQ,
            c_I_OPQ:    w_dstE = rB;
            c_I_CALL,
            c_I_RET,
            c_I_PUSHQ:  w_dstE = c_RSP;
            c_I_POPQ: begin
                w_dstE = c_RSP;
                w_dstM = rA;
            end
            c_I_MRMOVQ: w_dstM = rA;
            default: begin
                w_dstE = c_RNONE;
                w_dstM = c_RNONE;
            end
        endcase
    end

    assign w_commit = wb_en & ~r_halted;

    // One flop bank per register; the M port is checked first so that
    // valM wins when both destinations name the same register (popq %rsp).
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            localparam logic [3:0] c_ID = 4'(gi);
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_regs[gi] <= '0;
                end else if (w_commit && (w_dstM == c_ID)) begin
                    r_regs[gi] <= valM;
                end else if (w_commit && (w_dstE == c_ID)) begin
                    r_regs[gi] <= valE;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else if (w_commit) begin
            r_retired <= r_retired + 64'd1;
            if (icode == c_I_HALT) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Read ports: plain muxes over current state; ID 15 matches no entry
    // and therefore reads as zero.
    always_comb begin
        w_valA = '0;
        w_valB = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == 4'(i)) w_valA = r_regs[i];
            if (srcB == 4'(i)) w_valB = r_regs[i];
        end
    end

    assign valA    = w_valA;
    assign valB    = w_valB;
    assign dstE    = w_dstE;
    assign dstM    = w_dstM;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Directed self-checking bench for writeback_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [3:0]  icode, rA, rB, srcA, srcB;
    logic        Cnd;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB;
    logic [3:0]  dstE, dstM;
    logic        halted;
    logic [63:0] retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_regfile #(.NREGS(15), .WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .icode(icode), .rA(rA),
        .rB(rB), .Cnd(Cnd), .valE(valE), .valM(valM), .srcA(srcA),
        .srcB(srcB), .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM),
        .halted(halted), .retired(retired)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] id, input string tag,
                      input logic [63:0] exp);
        srcA = id;
        srcB = id;
        #1;
        check({tag, "_A"}, valA, exp);
        check({tag, "_B"}, valB, exp);
    endtask

    task automatic instr(input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c,
                         input logic [63:0] e, input logic [63:0] m);
        icode = ic; rA = a; rB = b; Cnd = c; valE = e; valM = m;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wb_en = 1'b0; icode = 4'd1; rA = 4'hF; rB = 4'hF;
        Cnd = 1'b0; valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF;

        // Reset state
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_retired", retired, 64'd0);
        for (int i = 0; i < 16; i++) rd(4'(i), "rst_reg", 64'd0);

        // 1: irmovq -> R2
        instr(4'd3, 4'hF, 4'd2, 1'b0, 64'h1234, 64'h0);
        check("irm_dstE", {60'd0, dstE}, 64'd2);
        check("irm_dstM", {60'd0, dstM}, 64'd15);
        wb_en = 1'b1; tick(); wb_en = 1'b0;
        rd(4'd2, "irm_R2", 64'h1234);
        check("irm_retired", retired, 64'd1);
        for (int i = 0; i < 15; i++) if (i != 2) rd(4'(i), "irm_other", 64'd0);

        // 2: cmov not taken, then taken
        instr(4'd2, 4'd0, 4'd3, 1'b0, 64'hAA, 64'h0);
        check("cmov0_dstE", {60'd0, dstE}, 64'd15);
        wb_en = 1'b1; tick(); wb_en = 1'b0;
        rd(4'd3, "cmov0_R3", 64'd0);
        rd(4'd0, "cmov0_R0", 64'd0);
        check("cmov0_retired", retired, 64'd2);
        instr(4'd2, 4'd0, 4'd3, 1'b1, 64'hAA, 64'h0);
        check("cmov1_dstE", {60'd0, dstE}, 64'd3);
        wb_en = 1'b1; tick(); wb_en = 1'b0;
        rd(4'd3, "cmov1_R3", 64'hAA);

        // 3: popq %rsp then popq %rcx
        instr(4'd11, 4'd4, 4'hF, 1'b0, 64'h108, 64'h55);
        check("pop4_dstE", {60'd0, dstE}, 64'd4);
        check("pop4_dstM", {60'd0, dstM}, 64'd4);
        wb_en = 1'b1; tick(); wb_en = 1'b0;
        rd(4'd4, "pop4_R4", 64'h55);
        instr(4'd11, 4'd1, 4'hF, 1'b0, 64'h110, 64'h77);
        check("pop1_dstM", {60'd0, dstM}, 64'd1);
        wb_en = 1'b1; tick(); wb_en = 1'b0;
        rd(4'd1, "pop1_R1", 64'h77);
        rd(4'd4, "pop1_R4", 64'h110);
        check("pop_retired", retired, 64'd5);

        // 4: same-cycle read/write has no bypass
        instr(4'd3, 4'hF, 4'd2, 1'b0, 64'h9, 64'h0);
        wb_en = 1'b1;
        rd(4'd2, "rw_before", 64'h1234);
        tick(); wb_en = 1'b0;
        rd(4'd2, "rw_after", 64'h9);
        rd(4'hF, "rw_rnone", 64'd0);

        // Invalid icode: count only
        instr(4'd12, 4'd2, 4'd2, 1'b1, 64'hDEAD, 64'hBEEF);
        check("inv_dstE", {60'd0, dstE}, 64'd15);
        wb_en = 1'b1; tick(); wb_en = 1'b0;
        check("inv_retired", retired, 64'd7);
        check("inv_halted", {63'd0, halted}, 64'd0);
        rd(4'd2, "inv_R2", 64'h9);

        // wb_en low: nothing changes
        instr(4'd3, 4'hF, 4'd7, 1'b0, 64'h77, 64'h0);
        tick();
        rd(4'd7, "noen_R7", 64'd0);
        check("noen_retired", retired, 64'd7);

        // 5: HALT then ignored commits, then reset
        instr(4'd0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        wb_en = 1'b1; tick();
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_retired", retired, 64'd8);
        instr(4'd6, 4'd0, 4'd5, 1'b0, 64'd7, 64'h0);
        check("halt_dstE", {60'd0, dstE}, 64'd5);
        tick(); wb_en = 1'b0;
        rd(4'd5, "halt_R5", 64'd0);
        check("halt_retired2", retired, 64'd8);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("hrst_halted", {63'd0, halted}, 64'd0);
        check("hrst_retired", retired, 64'd0);
        rd(4'd2, "hrst_R2", 64'd0);

        // 6: reset beats wb_en; reset waits for the edge
        instr(4'd3, 4'hF, 4'd6, 1'b0, 64'h66, 64'h0);
        wb_en = 1'b1; tick();
        rd(4'd6, "r6_pre", 64'h66);
        instr(4'd3, 4'hF, 4'd6, 1'b0, 64'h99, 64'h0);
        rst_n = 1'b0;
        rd(4'd6, "r6_noedge", 64'h66);
        check("noedge_retired", retired, 64'd1);
        tick();
        rst_n = 1'b1; wb_en = 1'b0;
        rd(4'd6, "r6_reset", 64'd0);
        check("r6_retired", retired, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
